// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller for the external, timer and UART sources.
// It latches edge requests, masks them, and picks the lowest index as the winner.
// The winner is offered to the pipeline with an irq_req/irq_taken handshake.
// The controller then stays in service until ERET. Interrupts do not nest.

// irq_src_cell: per-source pending logic.
// Edge sources latch a rising edge until acknowledged. Level sources pass the line straight through.
module irq_src_cell #(
    parameter bit IS_EDGE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic src_i,
    input  logic clr_i,
    output logic pend_o
);

    logic src_prev_q;
    logic pend_q;
    logic pend_d;
    logic rise;

    assign rise = src_i & ~src_prev_q;

    // A fresh edge beats a clear in the same cycle so the new request is not lost
    always_comb begin
        pend_d = pend_q;
        if (rise) begin
            pend_d = 1'b1;
        end else if (clr_i) begin
            pend_d = 1'b0;
        end
    end

    // Edge detector history and pending latch
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_prev_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            src_prev_q <= src_i;
            pend_q     <= pend_d;
        end
    end

    assign pend_o = IS_EDGE ? pend_q : src_i;

endmodule

module irq_ctrl #(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] EDGE_MASK = 8'b0000_0001,
    parameter int         ID_W      = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] int_src,
    input  logic [NUM_SRC-1:0] int_mask,
    input  logic               global_ie,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_taken,
    input  logic               eret,
    output logic [NUM_SRC-1:0] int_ack,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_service
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               irq_req_q, irq_req_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [NUM_SRC-1:0] int_ack_q, int_ack_d;
    logic               in_svc_q, in_svc_d;

    logic [NUM_SRC-1:0] pend_vec;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] id_hot;
    logic [NUM_SRC-1:0] clr_vec;
    logic [ID_W-1:0]    win_id;
    logic               accept;
    logic               cur_elig;

    // One pending cell per source; edge or level behaviour is chosen by EDGE_MASK
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_src_cell #(
            .IS_EDGE (EDGE_MASK[g])
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .src_i   (int_src[g]),
            .clr_i   (clr_vec[g]),
            .pend_o  (pend_vec[g])
        );
    end

    assign eligible = pend_vec & int_mask & {NUM_SRC{global_ie}};
    assign accept   = (state_q == S_REQ) && irq_taken;
    assign clr_vec  = accept ? id_hot : '0;
    assign cur_elig = |(eligible & id_hot);

    // Decode the frozen request id into a one-hot vector for ack, clear and the drop check
    always_comb begin
        id_hot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_hot[i] = (irq_id_q == ID_W'(i));
        end
    end

    // Fixed priority: scan from the top down so that the lowest eligible index is written last
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // Request / service sequencing. The ack pulse defaults low so that it lasts exactly one cycle.
    always_comb begin
        state_d   = state_q;
        irq_req_d = irq_req_q;
        irq_id_d  = irq_id_q;
        in_svc_d  = in_svc_q;
        int_ack_d = '0;
        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    state_d   = S_REQ;
                    irq_id_d  = win_id;
                    irq_req_d = 1'b1;
                end
            end
            S_REQ: begin
                // taken wins over a request that is withdrawn in the same cycle
                if (irq_taken) begin
                    state_d   = S_SERVICE;
                    irq_req_d = 1'b0;
                    in_svc_d  = 1'b1;
                    int_ack_d = id_hot;
                end else if (!cur_elig) begin
                    state_d   = S_IDLE;
                    irq_req_d = 1'b0;
                end
            end
            S_SERVICE: begin
                if (eret) begin
                    state_d  = S_IDLE;
                    in_svc_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                irq_req_d = 1'b0;
                in_svc_d  = 1'b0;
            end
        endcase
    end

    // Controller state registers; a reset aborts any request or service in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            irq_req_q <= 1'b0;
            irq_id_q  <= '0;
            int_ack_q <= '0;
            in_svc_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
            int_ack_q <= int_ack_d;
            in_svc_q  <= in_svc_d;
        end
    end

    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign int_ack    = int_ack_q;
    assign pending    = pend_vec;
    assign in_service = in_svc_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl. It runs the directed scenarios first, then randomized traffic.
// A cycle-level reference model of the interrupt rules is checked on every cycle.
module tb_irq_ctrl;

    localparam logic [3:0] EDGE = 4'b0001;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] int_src;
    logic [3:0] int_mask;
    logic       global_ie;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       irq_taken;
    logic       eret;
    logic [3:0] int_ack;
    logic [3:0] pending;
    logic       in_service;

    int checks = 0;
    int errors = 0;

    // reference model state: which phase, latched edges, last line values
    int         m_mode;   // 0 waiting, 1 offered, 2 handler running
    logic [3:0] m_pend;
    logic [3:0] m_prev;
    logic [3:0] m_ack;
    logic       m_req;
    logic       m_svc;
    int         m_id;

    irq_ctrl #(.NUM_SRC(4), .EDGE_MASK(8'b0000_0001), .ID_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .int_src    (int_src),
        .int_mask   (int_mask),
        .global_ie  (global_ie),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_taken  (irq_taken),
        .eret       (eret),
        .int_ack    (int_ack),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_pending();
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = EDGE[i] ? m_pend[i] : int_src[i];
        return p;
    endfunction

    // Apply the interrupt rules for one clock edge, using the inputs held across it
    task automatic model_edge();
        logic [3:0] elig;
        int clr;
        clr = -1;
        if (!reset_n) begin
            m_mode = 0; m_pend = '0; m_prev = '0; m_ack = '0;
            m_req = 0; m_svc = 0; m_id = 0;
            return;
        end
        elig  = model_pending() & int_mask & (global_ie ? 4'hF : 4'h0);
        m_ack = '0;
        if (m_mode == 0) begin
            if (elig != 0) begin
                for (int i = 3; i >= 0; i--) if (elig[i]) m_id = i;
                m_req = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (irq_taken) begin
                m_mode = 2; m_req = 0; m_svc = 1;
                m_ack[m_id] = 1'b1; clr = m_id;
            end else if (!elig[m_id]) begin
                m_mode = 0; m_req = 0;
            end
        end else begin
            if (eret) begin
                m_mode = 0; m_svc = 0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (int_src[i] && !m_prev[i]) m_pend[i] = 1'b1;
            else if (clr == i)            m_pend[i] = 1'b0;
        end
        m_prev = int_src;
    endtask

    task automatic compare_all();
        chk("m_req", {31'd0, irq_req}, {31'd0, m_req});
        if (m_req) chk("m_id", {29'd0, irq_id}, m_id);
        chk("m_ack", {28'd0, int_ack}, {28'd0, m_ack});
        chk("m_svc", {31'd0, in_service}, {31'd0, m_svc});
        chk("m_pend", {28'd0, pending}, {28'd0, model_pending()});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        reset_n = 0; int_src = 0; int_mask = 4'hF; global_ie = 1; irq_taken = 0; eret = 0;
        m_mode = 0; m_pend = 0; m_prev = 0; m_ack = 0; m_req = 0; m_svc = 0; m_id = 0;
        cycle(); cycle();
        chk("rst_req", {31'd0, irq_req}, 0);
        chk("rst_ack", {28'd0, int_ack}, 0);
        chk("rst_pend", {28'd0, pending}, 0);
        chk("rst_svc", {31'd0, in_service}, 0);
        reset_n = 1; cycle();

        // basic: external edge source
        int_src = 4'b0001; cycle();
        chk("t1_pend_e0", {28'd0, pending}, 4'b0001);
        chk("t1_req_e0", {31'd0, irq_req}, 0);
        cycle();
        chk("t1_req_e1", {31'd0, irq_req}, 1);
        chk("t1_id", {29'd0, irq_id}, 0);
        int_src = 0; irq_taken = 1; cycle(); irq_taken = 0;
        chk("t1_ack", {28'd0, int_ack}, 4'b0001);
        chk("t1_svc", {31'd0, in_service}, 1);
        chk("t1_pend_clr", {28'd0, pending}, 0);
        cycle();
        chk("t1_ack_one", {28'd0, int_ack}, 0);
        eret = 1; cycle(); eret = 0;
        chk("t1_eret", {31'd0, in_service}, 0);

        // priority between simultaneous sources 2 and 1
        int_src = 4'b0110; cycle();
        chk("t2_req", {31'd0, irq_req}, 1);
        chk("t2_id1", {29'd0, irq_id}, 1);
        irq_taken = 1; cycle(); irq_taken = 0;
        chk("t2_ack", {28'd0, int_ack}, 4'b0010);
        int_src = 4'b0100; eret = 1; cycle(); eret = 0;
        chk("t2_idle_gap", {31'd0, irq_req}, 0);
        cycle();
        chk("t2_req2", {31'd0, irq_req}, 1);
        chk("t2_id2", {29'd0, irq_id}, 2);
        irq_taken = 1; cycle(); irq_taken = 0; int_src = 0;
        eret = 1; cycle(); eret = 0; cycle();

        // IE drops while a request is outstanding
        int_src = 4'b0001; cycle(); cycle();
        chk("t3_req", {31'd0, irq_req}, 1);
        global_ie = 0; cycle();
        chk("t3_drop", {31'd0, irq_req}, 0);
        chk("t3_noack", {28'd0, int_ack}, 0);
        chk("t3_pend", {28'd0, pending}, 4'b0001);
        global_ie = 1; cycle();
        chk("t3_reissue", {31'd0, irq_req}, 1);
        irq_taken = 1; cycle(); irq_taken = 0; int_src = 0;
        eret = 1; cycle(); eret = 0; cycle();

        // level source 3
        int_src = 4'b1000; cycle();
        chk("t4_req", {29'd0, irq_id}, 3);
        irq_taken = 1; cycle(); irq_taken = 0;
        chk("t4_ack", {28'd0, int_ack}, 4'b1000);
        int_src = 0; cycle(); eret = 1; cycle(); eret = 0; cycle(); cycle();
        chk("t4_none", {31'd0, irq_req}, 0);
        int_src = 4'b1000; cycle(); irq_taken = 1; cycle(); irq_taken = 0;
        eret = 1; cycle(); eret = 0; cycle();
        chk("t4_held", {31'd0, irq_req}, 1);
        chk("t4_held_id", {29'd0, irq_id}, 3);
        int_src = 0; cycle();
        chk("t4_fell", {31'd0, irq_req}, 0);

        // new edge on source 0 in the same cycle as its ack
        int_src = 4'b0001; cycle(); cycle();
        int_src = 0; cycle();
        int_src = 4'b0001; irq_taken = 1; cycle(); irq_taken = 0;
        chk("t5_ack", {28'd0, int_ack}, 4'b0001);
        chk("t5_keep", {28'd0, pending}, 4'b0001);
        eret = 1; cycle(); eret = 0; cycle();
        chk("t5_req2", {31'd0, irq_req}, 1);
        chk("t5_id2", {29'd0, irq_id}, 0);
        irq_taken = 1; cycle(); irq_taken = 0; eret = 1; cycle(); eret = 0;
        int_src = 0; cycle();

        // reset in the middle of REQ
        int_src = 4'b0001; cycle(); cycle();
        chk("t6_req", {31'd0, irq_req}, 1);
        reset_n = 0; cycle(); reset_n = 1; int_src = 0;
        chk("t6_req0", {31'd0, irq_req}, 0);
        chk("t6_ack0", {28'd0, int_ack}, 0);
        chk("t6_pend0", {28'd0, pending}, 0);
        cycle();
        chk("t6_idle", {31'd0, irq_req}, 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int_src   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            int_mask  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            global_ie = ($urandom_range(0, 9) != 0);
            irq_taken = ($urandom_range(0, 2) == 0);
            eret      = ($urandom_range(0, 3) == 0);
            reset_n   = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller between the board-level interrupt sources (button-driven external interrupt, timer, UART) and the 5-stage pipeline's exception/CP0 logic.
- Latches and masks requests, and picks one by fixed priority. Presents it to the pipeline with a request/taken handshake.
- On acceptance, returns a one-cycle acknowledge pulse to the winning source. Bit 0 drives the external interrupt block's ext_int_ack.
- Holds an in-service state until the pipeline executes ERET. Interrupts do not nest.

Parameters:
- NUM_SRC, 4: number of interrupt sources, 1..8.
- EDGE_MASK, 4'b0001: per source, 1 = rising-edge-triggered (latched), 0 = level-triggered (not latched).
- ID_W, 3: width of irq_id, at least clog2(NUM_SRC).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- int_src  in  NUM_SRC  raw interrupt lines, already synchronous to clk; index 0 = external_int
- int_mask  in  NUM_SRC  per-source enable from the CP0 Status IM field; 1 = enabled
- global_ie  in  1  CP0 Status IE bit
- irq_req  out  1  registered request to the pipeline
- irq_id  out  ID_W  index of the requested source; stable while irq_req=1
- irq_taken  in  1  one-cycle pulse: pipeline has committed to the exception for irq_id
- eret  in  1  one-cycle pulse: ERET retired
- int_ack  out  NUM_SRC  one-hot, one-cycle acknowledge to the source
- pending  out  NUM_SRC  current pending vector, for the CP0 Cause IP field
- in_service  out  1  high while a handler is running

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; irq_req, irq_id, int_ack, in_service, pending latches and src_prev all 0. Reset asserted mid-REQ or mid-SERVICE aborts immediately; no ack is issued.
- Edge source i: src_prev[i] registers int_src[i]. pending[i] sets at the edge where int_src[i]=1 and src_prev[i]=0, and clears at acknowledge.
- Level source i: pending[i] = int_src[i], combinational.
- eligible = pending & int_mask, gated by global_ie. Winner = lowest set index (index 0 highest priority).
- States: IDLE, REQ, SERVICE.
- IDLE -> REQ at the edge where eligible != 0. At that edge: irq_id <= winner, irq_req <= 1.
- Timing: int_src rises before edge E0, pending at E0, irq_req=1 after E1, i.e. 2 cycles.
- REQ: irq_id is frozen. A higher-priority arrival does not pre-empt an outstanding request.
- REQ, irq_taken=1 -> SERVICE. At that edge: irq_req <= 0, in_service <= 1, int_ack <= onehot(irq_id) for exactly 1 cycle, and pending[irq_id] clears if it is an edge source.
- REQ, irq_taken=0 and eligible[irq_id]=0 (masked, IE dropped, or level line fell) -> IDLE, irq_req <= 0, no ack. If irq_taken=1 arrives in the same cycle, taken wins.
- SERVICE, eret=1 -> IDLE, in_service <= 0. New requests are evaluated from the next cycle, so there are no back-to-back requests without one IDLE cycle.
- SERVICE: pending keeps latching new edges, and no request is issued.
- eret outside SERVICE: ignored. irq_taken outside REQ: ignored.
- Simultaneous new rising edge and clear on the same bit: set wins, so pending stays 1.
- int_ack is 0 in every cycle other than the single ack cycle.

Test Plan:
- Reset, then int_src=4'b0001, int_mask=4'hF, global_ie=1 -> pending[0]=1 after 1 edge, irq_req=1 with irq_id=0 after 2 edges. Then irq_taken pulse -> int_ack=4'b0001 for one cycle, in_service=1, pending=0.
- int_src bits 2 and 1 rise in the same cycle -> irq_id=1. After taken and eret, a second request appears with irq_id=2 after one IDLE cycle.
- irq_req=1 for id 0, then global_ie falls before irq_taken -> irq_req=0 next cycle, int_ack stays 0, pending[0] stays 1. Raising global_ie again -> request re-issued.
- Level source 3 (EDGE_MASK=4'b0001) held high, taken, then dropped during SERVICE -> no request after eret. Held high through eret -> request re-issued.
- New edge on src 0 at the same edge as its ack -> pending[0] remains 1, and a second request with id 0 follows eret.
- reset_n=0 for one cycle while in REQ -> next cycle irq_req=0, int_ack=0, pending=0, state IDLE.
